dro_pulse_sequencer: RTL and testbench

Clocked stimulus-and-readback stage that sits directly upstream of basic_dro and also observes its output. It accepts one command at a time (store, read, or no-op), generates registered set/reset pulses of programmable width for the DRO, and samples the DRO output in a response window after each read pulse. It reports each read result and flags mismatches against the bit it expects the DRO to hold. It serves as the reusable driver and scoreboard for DRO benches and VCD assertion runs.

---
 rtl/dro_pulse_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_dro_pulse_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dro_pulse_sequencer.sv
// dro_pulse_sequencer
//   Driver and scoreboard for a destructive-readout (DRO) cell. Accepts one
//   command at a time (NOP / SET / READ), produces registered set or reset
//   pulses PULSE_W cycles wide, samples dro_out across the read pulse plus WIN
//   further cycles, and reports the read result together with an error strobe
//   whenever the DRO output disagrees with the bit it is expected to hold or
//   fires outside a read window.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_op                  00 NOP, 01 SET, 10 READ, 11 illegal
//   cmd_gap                 idle cycles inserted after the command completes
//   set, reset              DRO pulse outputs
//   dro_out                 DRO output, sampled on clk
//   rd_valid, rd_data       one-cycle read result strobe and value
//   err                     one-cycle error strobe
//   busy                    sequencer not idle
//   set_count, read_count   saturating statistics counters
module dro_pulse_sequencer #(
  parameter int PULSE_W = 2,
  parameter int WIN     = 4,
  parameter int GAP_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GAP_W-1:0] cmd_gap,
  output logic             set,
  output logic             reset,
  input  logic             dro_out,
  output logic             rd_valid,
  output logic             rd_data,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] set_count,
  output logic [CNT_W-1:0] read_count
);

  typedef enum logic [1:0] {IDLE, PULSE, WINDOW, GAP} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // One down-counter is shared by the pulse, window and gap phases, so it
  // must be wide enough for whichever of them is longest.
  localparam int TW = (GAP_W > 16) ? GAP_W : 16;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       op_q, op_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             expected_q, expected_d;
  logic             seen_q, seen_d;
  logic             in_window, seen_now;

  logic             cmd_ready_d, set_d, reset_d, rd_valid_d, rd_data_d, err_d, busy_d;
  logic [CNT_W-1:0] set_count_d, read_count_d;

  // Next-state and next-output logic. Every output is computed here and then
  // registered, so the DRO sees glitch-free pulses aligned to clk.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    op_d         = op_q;
    gap_d        = gap_q;
    expected_d   = expected_q;
    seen_d       = seen_q;
    set_d        = 1'b0;
    reset_d      = 1'b0;
    rd_valid_d   = 1'b0;
    rd_data_d    = 1'b0;
    set_count_d  = set_count;
    read_count_d = read_count;
    seen_now     = seen_q | dro_out;

    // The read window spans the reset pulse itself plus the WIN tail cycles;
    // any DRO activity elsewhere is treated as spurious.
    in_window = ((state_q == PULSE) && (op_q == OP_READ)) || (state_q == WINDOW);
    err_d     = dro_out && !in_window;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          gap_d  = cmd_gap;
          seen_d = 1'b0;
          if (cmd_op == OP_SET || cmd_op == OP_READ) begin
            state_d = PULSE;
            timer_d = TW'(PULSE_W - 1);
            set_d   = (cmd_op == OP_SET);
            reset_d = (cmd_op == OP_READ);
            if (cmd_op == OP_SET && set_count != '1)
              set_count_d = set_count + CNT_W'(1);
          end else begin
            if (cmd_op == OP_ILL)
              err_d = 1'b1;
            if (cmd_gap != '0) begin
              state_d = GAP;
              timer_d = TW'(cmd_gap) - TW'(1);
            end
          end
        end
      end

      PULSE: begin
        if (op_q == OP_READ)
          seen_d = seen_now;
        if (timer_q == '0) begin
          if (op_q == OP_READ) begin
            state_d = WINDOW;
            timer_d = TW'(WIN - 1);
          end else begin
            // SET is idempotent: storing into a full DRO keeps the bit at 1.
            expected_d = 1'b1;
            if (gap_q != '0) begin
              state_d = GAP;
              timer_d = TW'(gap_q) - TW'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          timer_d = timer_q - TW'(1);
          set_d   = (op_q == OP_SET);
          reset_d = (op_q == OP_READ);
        end
      end

      WINDOW: begin
        seen_d = seen_now;
        if (timer_q == '0) begin
          // A read is destructive, so the expected bit always clears here.
          rd_valid_d = 1'b1;
          rd_data_d  = seen_now;
          if (seen_now != expected_q)
            err_d = 1'b1;
          expected_d = 1'b0;
          if (read_count != '1)
            read_count_d = read_count + CNT_W'(1);
          if (gap_q != '0) begin
            state_d = GAP;
            timer_d = TW'(gap_q) - TW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      GAP: begin
        if (timer_q == '0)
          state_d = IDLE;
        else
          timer_d = timer_q - TW'(1);
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset clears everything, even mid-pulse, so
  // cmd_ready only rises on the first clock after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      op_q       <= OP_NOP;
      gap_q      <= '0;
      expected_q <= 1'b0;
      seen_q     <= 1'b0;
      cmd_ready  <= 1'b0;
      set        <= 1'b0;
      reset      <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      set_count  <= '0;
      read_count <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      op_q       <= op_d;
      gap_q      <= gap_d;
      expected_q <= expected_d;
      seen_q     <= seen_d;
      cmd_ready  <= cmd_ready_d;
      set        <= set_d;
      reset      <= reset_d;
      rd_valid   <= rd_valid_d;
      rd_data    <= rd_data_d;
      err        <= err_d;
      busy       <= busy_d;
      set_count  <= set_count_d;
      read_count <= read_count_d;
    end
  end

endmodule

// File: tb/tb_dro_pulse_sequencer.sv
// tb_dro_pulse_sequencer
//   Directed scenarios followed by a random run. Expected outputs come from a
//   command-level model: each accepted command is turned into cycle ranges for
//   the set/reset pulses, the read window and the busy period, and the read
//   result is the OR of dro_out over the window edges.
module tb_dro_pulse_sequencer;

  localparam int PULSE_W = 2;
  localparam int WIN     = 4;
  localparam int GAP_W   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] SET  = 2'b01;
  localparam logic [1:0] READ = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [GAP_W-1:0] cmd_gap = '0;
  logic             set, reset, dro_out = 1'b0;
  logic             rd_valid, rd_data, err, busy;
  logic [CNT_W-1:0] set_count, read_count;

  dro_pulse_sequencer #(
    .PULSE_W(PULSE_W), .WIN(WIN), .GAP_W(GAP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_gap(cmd_gap), .set(set), .reset(reset),
    .dro_out(dro_out), .rd_valid(rd_valid), .rd_data(rd_data), .err(err),
    .busy(busy), .set_count(set_count), .read_count(read_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc;
  int   ready_cyc;
  int   set_lo, set_hi, rst_lo, rst_hi, win_lo, win_hi;
  logic acc, exp_bit;
  int   set_cnt, read_cnt;
  logic e_err, e_rdv, e_rdd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle n is the interval after clock edge n counted from reset release.
  task automatic model_init();
    cyc       = 0;
    ready_cyc = 1;
    set_lo = 0; set_hi = -1;
    rst_lo = 0; rst_hi = -1;
    win_lo = 0; win_hi = -1;
    acc = 1'b0; exp_bit = 1'b0;
    set_cnt = 0; read_cnt = 0;
    e_err = 1'b0; e_rdv = 1'b0; e_rdd = 1'b0;
  endtask

  // Applies the rules to the edge that is about to happen (edge cyc+1).
  task automatic model_edge(input logic v, input logic [1:0] op, input int g, input logic d);
    int   e;
    logic in_win;
    e      = cyc + 1;
    e_err  = 1'b0;
    e_rdv  = 1'b0;
    e_rdd  = 1'b0;
    in_win = (e >= win_lo) && (e <= win_hi);
    if (in_win) begin
      acc = acc | d;
      if (e == win_hi) begin
        e_rdv = 1'b1;
        e_rdd = acc;
        if (acc != exp_bit) e_err = 1'b1;
        exp_bit = 1'b0;
        if (read_cnt < CNT_MAX) read_cnt++;
      end
    end else if (d) begin
      e_err = 1'b1;
    end
    if (v && cyc >= ready_cyc) begin
      case (op)
        SET: begin
          set_lo = e; set_hi = e + PULSE_W - 1;
          exp_bit = 1'b1;
          if (set_cnt < CNT_MAX) set_cnt++;
          ready_cyc = e + PULSE_W + g;
        end
        READ: begin
          rst_lo = e; rst_hi = e + PULSE_W - 1;
          win_lo = e + 1; win_hi = e + PULSE_W + WIN;
          acc = 1'b0;
          ready_cyc = e + PULSE_W + WIN + g;
        end
        default: begin
          if (op == ILL) e_err = 1'b1;
          ready_cyc = e + g;
        end
      endcase
    end
  endtask

  task automatic checkOutput();
    chk("set",        32'(set),        32'((cyc >= set_lo) && (cyc <= set_hi)));
    chk("reset",      32'(reset),      32'((cyc >= rst_lo) && (cyc <= rst_hi)));
    chk("rd_valid",   32'(rd_valid),   32'(e_rdv));
    if (e_rdv) chk("rd_data", 32'(rd_data), 32'(e_rdd));
    chk("err",        32'(err),        32'(e_err));
    chk("busy",       32'(busy),       32'(cyc < ready_cyc));
    chk("cmd_ready",  32'(cmd_ready),  32'(cyc >= ready_cyc));
    chk("set_count",  32'(set_count),  32'(set_cnt));
    chk("read_count", 32'(read_count), 32'(read_cnt));
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input int g, input logic d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_gap   = GAP_W'(g);
    dro_out   = d;
    model_edge(v, op, g, d);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n, input logic d);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, NOP, 0, d);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_set"},       32'(set),        0);
    chk({tag, "_reset"},     32'(reset),      0);
    chk({tag, "_rd_valid"},  32'(rd_valid),   0);
    chk({tag, "_err"},       32'(err),        0);
    chk({tag, "_busy"},      32'(busy),       0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready),  0);
    chk({tag, "_set_cnt"},   32'(set_count),  0);
    chk({tag, "_read_cnt"},  32'(read_count), 0);
  endtask

  // Drops rst_n immediately, checks the asynchronous clear, holds reset for
  // two clocks and releases it on a falling edge.
  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    dro_out   = 1'b0;
    #1;
    check_all_zero(tag);
    repeat (2) @(negedge clk);
    check_all_zero({tag, "_held"});
    rst_n = 1'b1;
    model_init();
  endtask

  initial begin
    #1;
    do_reset("por");

    // SET then READ, DRO answers one cycle after reset rises.
    idle(1, 1'b0);
    applyStimulus(1'b1, SET, 0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, READ, 0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(6, 1'b0);
    chk("t1_set_count",  32'(set_count),  1);
    chk("t1_read_count", 32'(read_count), 1);

    // READ with nothing stored, then READ after SET with a silent DRO.
    applyStimulus(1'b1, READ, 0, 1'b0);
    idle(7, 1'b0);
    applyStimulus(1'b1, SET, 0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, READ, 0, 1'b0);
    idle(7, 1'b0);

    // Spurious DRO output in IDLE and during a SET pulse.
    idle(1, 1'b1);
    idle(2, 1'b0);
    applyStimulus(1'b1, SET, 0, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    applyStimulus(1'b1, READ, 0, 1'b0);
    idle(7, 1'b1);

    // Illegal op, then NOP with a 5-cycle gap.
    applyStimulus(1'b1, ILL, 0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, NOP, 5, 1'b0);
    idle(7, 1'b0);

    // Reset in the second cycle of a read pulse, then a clean READ.
    applyStimulus(1'b1, READ, 0, 1'b0);
    applyStimulus(1'b0, NOP, 0, 1'b0);
    chk("t5_reset_pulse", 32'(reset), 1);
    do_reset("midpulse");
    idle(1, 1'b0);
    applyStimulus(1'b1, READ, 0, 1'b0);
    idle(7, 1'b0);

    // Back-to-back SETs with cmd_valid held high until the counter saturates.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, SET, 0, 1'b0);
    chk("t6_set_count_sat", 32'(set_count), CNT_MAX);

    // Random command mix against the model.
    for (int i = 0; i < 1500; i++) begin
      int         r;
      logic [1:0] op;
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? SET : (r < 8) ? READ : (r == 8) ? NOP : ILL;
      applyStimulus($urandom_range(0, 2) != 0, op, int'($urandom_range(0, 3)),
                    $urandom_range(0, 6) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
